cmos_dvp_tx: RTL and testbench

- Transmitter end of the 8-bit CMOS DVP camera interface. It accepts 16-bit RGB565 pixels over a valid/ready handshake and serialises them into vsync/href/byte-data frames, high byte first.
- Output is byte-compatible with the RGB565 capture path. Used to drive processed video onto a DVP link, or as a synthesizable sensor model in benches.

---
 rtl/cmos_dvp_tx_if.sv | 19 +
 rtl/cmos_dvp_tx.sv | 208 ++++++++++++++++++++
 tb/tb_cmos_dvp_tx.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmos_dvp_tx_if.sv
// Pixel stream handshake between an RGB565 source and the DVP transmitter.
// A pixel moves at a rising clock edge where pix_valid and pix_ready are both high.
interface cmos_dvp_tx_if;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;

  modport master (
    output pix_valid,
    output pix_data,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    output pix_ready
  );
endinterface

// File: rtl/cmos_dvp_tx.sv
// 8-bit DVP transmitter: serialises RGB565 pixels into vsync/href/byte frames, high byte first.
// Define CMOS_DVP_TX_PATTERN_EN to add pattern_sel and an internal {y,x} test pattern source.
module cmos_dvp_tx #(
  parameter int unsigned IMG_HDISP        = 640,
  parameter int unsigned IMG_VDISP        = 480,
  parameter int unsigned VSYNC_CLKS       = 16,
  parameter int unsigned V_BACK_CLKS      = 64,
  parameter int unsigned H_BLANK_CLKS     = 32,
  parameter int unsigned V_FRONT_CLKS     = 64,
  parameter logic        CMOS_VSYNC_VALID = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  cmos_dvp_tx_if.slave      pix,
`ifdef CMOS_DVP_TX_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic              cmos_vsync,
  output logic              cmos_href,
  output logic [7:0]        cmos_data,
  output logic              frame_done,
  output logic              underflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_LINE,
    S_HBLANK,
    S_VFRONT
  } state_t;

  localparam logic [15:0] VSYNC_LAST  = 16'(VSYNC_CLKS - 1);
  localparam logic [15:0] VBACK_LAST  = 16'(V_BACK_CLKS - 1);
  localparam logic [15:0] HBLANK_LAST = 16'(H_BLANK_CLKS - 1);
  localparam logic [15:0] VFRONT_LAST = 16'(V_FRONT_CLKS - 1);
  localparam logic [11:0] X_LAST      = 12'(IMG_HDISP - 1);
  localparam logic [11:0] Y_LAST      = 12'(IMG_VDISP - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [11:0] x;
  logic [11:0] y;
  logic        phase_l;
  logic [15:0] pix_hold;
  logic        pat_on;

  logic        ready_slot;
  logic        start_frame;
  logic        starve;
  logic [15:0] next_pix;

  // A pixel is fetched in the cycle right before every high-byte cycle.
  always_comb begin
    ready_slot = 1'b0;
    case (state)
      S_VBACK:  ready_slot = (cnt == VBACK_LAST);
      S_HBLANK: ready_slot = (cnt == HBLANK_LAST) && (y != Y_LAST);
      S_LINE:   ready_slot = phase_l && (x != X_LAST);
      default:  ready_slot = 1'b0;
    endcase
  end

  assign start_frame = enable &&
                       ((state == S_IDLE) || ((state == S_VFRONT) && (cnt == VFRONT_LAST)));

  assign pix.pix_ready = ready_slot & ~pat_on;
  assign starve        = ~pat_on & ~pix.pix_valid;

`ifdef CMOS_DVP_TX_PATTERN_EN
  logic [7:0] pat_x;
  logic [7:0] pat_y;

  // Coordinates of the pixel being fetched, not of the one currently on the wire.
  always_comb begin
    pat_x = '0;
    pat_y = '0;
    case (state)
      S_LINE: begin
        pat_x = x[7:0] + 8'd1;
        pat_y = y[7:0];
      end
      S_HBLANK: pat_y = y[7:0] + 8'd1;
      default: ;
    endcase
  end

  always_comb begin
    next_pix = '0;
    if (pat_on)
      next_pix = {pat_y, pat_x};
    else if (pix.pix_valid)
      next_pix = pix.pix_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pat_on <= 1'b0;
    else if (start_frame)
      pat_on <= pattern_sel;
  end
`else
  assign pat_on   = 1'b0;
  assign next_pix = pix.pix_valid ? pix.pix_data : '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      x          <= '0;
      y          <= '0;
      phase_l    <= 1'b0;
      pix_hold   <= '0;
      cmos_vsync <= ~CMOS_VSYNC_VALID;
      cmos_href  <= 1'b0;
      cmos_data  <= '0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            state      <= S_VSYNC;
            cnt        <= '0;
            cmos_vsync <= CMOS_VSYNC_VALID;
            underflow  <= 1'b0;
          end
        end
        S_VSYNC: begin
          if (cnt == VSYNC_LAST) begin
            state      <= S_VBACK;
            cnt        <= '0;
            cmos_vsync <= ~CMOS_VSYNC_VALID;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_VBACK: begin
          if (cnt == VBACK_LAST) begin
            state <= S_LINE;
            cnt   <= '0;
            x     <= '0;
            y     <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_LINE: begin
          if (!phase_l) begin
            cmos_data <= pix_hold[7:0];
            phase_l   <= 1'b1;
          end else if (x == X_LAST) begin
            state     <= S_HBLANK;
            cnt       <= '0;
            phase_l   <= 1'b0;
            cmos_href <= 1'b0;
            cmos_data <= '0;
          end else begin
            x <= x + 12'd1;
          end
        end
        S_HBLANK: begin
          if (cnt == HBLANK_LAST) begin
            cnt <= '0;
            x   <= '0;
            y   <= y + 12'd1;
            if (y == Y_LAST) begin
              state      <= S_VFRONT;
              frame_done <= 1'b1;
            end else begin
              state <= S_LINE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_VFRONT: begin
          cnt <= (cnt == VFRONT_LAST) ? '0 : cnt + 16'd1;
          if (cnt == VFRONT_LAST) begin
            if (enable) begin
              state      <= S_VSYNC;
              cmos_vsync <= CMOS_VSYNC_VALID;
              underflow  <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // Pixel fetch is shared by all three line-entry points; it overrides the case above.
      if (ready_slot) begin
        pix_hold  <= next_pix;
        cmos_data <= next_pix[15:8];
        cmos_href <= 1'b1;
        phase_l   <= 1'b0;
        if (starve)
          underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// Scoreboard bench for cmos_dvp_tx: a frame-position model predicts sync timing and
// queues expected bytes at each predicted fetch; a negedge monitor compares DUT outputs.
module tb_cmos_dvp_tx;
  localparam int HD = 4;
  localparam int VD = 2;
  localparam int VS = 3;
  localparam int VB = 2;
  localparam int HB = 5;
  localparam int VF = 2;
  localparam int LW = 2 * HD + HB;
  localparam int LS = VS + VB;
  localparam int FR = LS + VD * LW;
  localparam int PER = FR + VF;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       cmos_vsync;
  logic       cmos_href;
  logic [7:0] cmos_data;
  logic       frame_done;
  logic       underflow;
`ifdef CMOS_DVP_TX_PATTERN_EN
  logic       pattern_sel = 1'b0;
`endif

  cmos_dvp_tx_if pif ();

  cmos_dvp_tx #(
    .IMG_HDISP       (HD),
    .IMG_VDISP       (VD),
    .VSYNC_CLKS      (VS),
    .V_BACK_CLKS     (VB),
    .H_BLANK_CLKS    (HB),
    .V_FRONT_CLKS    (VF),
    .CMOS_VSYNC_VALID(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pix        (pif),
`ifdef CMOS_DVP_TX_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .cmos_vsync (cmos_vsync),
    .cmos_href  (cmos_href),
    .cmos_data  (cmos_data),
    .frame_done (frame_done),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame geometry expressed as positions within one frame period.
  function automatic bit in_href(input int c);
    return (c >= LS) && (c < FR) && (((c - LS) % LW) < 2 * HD);
  endfunction

  function automatic bit is_hbyte(input int c);
    return in_href(c) && ((((c - LS) % LW) % 2) == 0);
  endfunction

  // Reference model: frame position and expected byte queue.
  bit         m_active = 0;
  int         m_c = 0;
  bit         m_uf = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0;
      m_c      = 0;
      m_uf     = 0;
      exp_q.delete();
    end else begin
      if (m_active && is_hbyte(m_c + 1)) begin
        if (pif.pix_valid) begin
          exp_q.push_back(pif.pix_data[15:8]);
          exp_q.push_back(pif.pix_data[7:0]);
        end else begin
          exp_q.push_back(8'h00);
          exp_q.push_back(8'h00);
          m_uf = 1;
        end
      end
      if (!m_active) begin
        if (enable) begin
          m_active = 1;
          m_c      = 0;
          m_uf     = 0;
        end
      end else if (m_c == PER - 1) begin
        if (enable) begin
          m_c  = 0;
          m_uf = 0;
        end else begin
          m_active = 0;
        end
      end else begin
        m_c++;
      end
    end
  end

  // Monitor.
  bit         cap_en = 0;
  logic [7:0] cap_q[$];
  int         rdy_cnt = 0;

  always @(negedge clk) begin
    logic [7:0] e;
    check("vsync", 16'(cmos_vsync), 16'(m_active && m_c < VS));
    check("href", 16'(cmos_href), 16'(m_active && in_href(m_c)));
    check("frame_done", 16'(frame_done), 16'(m_active && m_c == FR));
    check("pix_ready", 16'(pif.pix_ready), 16'(m_active && is_hbyte(m_c + 1)));
    check("underflow", 16'(underflow), 16'(m_uf));
    if (pif.pix_ready) rdy_cnt++;
    if (cmos_href) begin
      if (cap_en) cap_q.push_back(cmos_data);
      if (exp_q.size() == 0) begin
        check("data_queue_empty", 16'(exp_q.size()), 16'd1);
      end else begin
        e = exp_q.pop_front();
        check("data", 16'(cmos_data), 16'(e));
      end
    end else begin
      check("blank_data", 16'(cmos_data), 16'h0000);
    end
  end

  // Pixel source driver.
  int          drv_mode = 0;
  bit          en_rand = 0;
  int          tidx = 0;
  bit          rdy_prev = 0;
  logic [15:0] tbl[4] = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};

  always @(negedge clk) begin
    if (en_rand) enable = ($urandom_range(0, 7) != 0);
    case (drv_mode)
      0: begin
        pif.pix_valid = 1'b1;
        pif.pix_data  = 16'($urandom);
        tidx = 0;
      end
      1: begin
        pif.pix_valid = ($urandom_range(0, 3) != 0);
        pif.pix_data  = 16'($urandom);
        tidx = 0;
      end
      default: begin
        if (rdy_prev) tidx = (tidx + 1) % 4;
        pif.pix_valid = 1'b1;
        pif.pix_data  = tbl[tidx];
      end
    endcase
    rdy_prev = (drv_mode == 2) && pif.pix_ready;
  end

  task automatic wait_done(input int max_cycles);
    bit seen = 0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1;
        break;
      end
    end
    check("frame_done_seen", 16'(seen), 16'd1);
  endtask

  initial begin
    int cnt;
    int vs_len;
    logic [15:0] p;
    rst = 1'b1;
    enable = 1'b0;
    pif.pix_valid = 1'b0;
    pif.pix_data = '0;
    repeat (3) @(negedge clk);
    check("rst_vsync", 16'(cmos_vsync), 16'd0);
    check("rst_href", 16'(cmos_href), 16'd0);
    check("rst_data", 16'(cmos_data), 16'h00);
    check("rst_ready", 16'(pif.pix_ready), 16'd0);
    check("rst_done", 16'(frame_done), 16'd0);
    check("rst_underflow", 16'(underflow), 16'd0);
    rst = 1'b0;

    // Directed byte order from a fixed pixel table.
    drv_mode = 2;
    @(negedge clk);
    rdy_cnt = 0;
    cap_en = 1;
    enable = 1'b1;
    wait_done(3 * PER);
    cap_en = 0;
    check("ready_per_frame", 16'(rdy_cnt), 16'(HD * VD));
    check("captured_bytes", 16'(cap_q.size()), 16'(2 * HD * VD));
    for (int i = 0; i < cap_q.size() && i < 2 * HD * VD; i++) begin
      p = tbl[(i / 2) % 4];
      check("table_byte", 16'(cap_q[i]), (i % 2 == 0) ? 16'(p[15:8]) : 16'(p[7:0]));
    end

    // Frame period with enable held high.
    cnt = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      @(negedge clk);
      cnt++;
      if (frame_done) break;
    end
    check("frame_period", 16'(cnt), 16'(PER));

    // Random valid gaps and random enable.
    drv_mode = 1;
    en_rand = 1;
    repeat (500) @(negedge clk);
    en_rand = 0;
    enable = 1'b0;
    repeat (3 * PER) @(negedge clk);

    // enable dropped during line 1 still completes the frame.
    drv_mode = 0;
    enable = 1'b1;
    for (int i = 0; i < 3 * PER && !cmos_vsync; i++) @(negedge clk);
    check("vsync_start", 16'(cmos_vsync), 16'd1);
    repeat (LS + LW + 2) @(negedge clk);
    enable = 1'b0;
    wait_done(2 * PER);
    repeat (10) @(negedge clk);
    check("idle_vsync", 16'(cmos_vsync), 16'd0);
    check("idle_href", 16'(cmos_href), 16'd0);

    // Asynchronous reset in the middle of a line.
    enable = 1'b1;
    for (int i = 0; i < 3 * PER && !cmos_href; i++) @(negedge clk);
    check("href_start", 16'(cmos_href), 16'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_href", 16'(cmos_href), 16'd0);
    check("async_data", 16'(cmos_data), 16'h00);
    check("async_vsync", 16'(cmos_vsync), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmos_vsync || cmos_href) break;
    end
    check("first_vsync", 16'(cmos_vsync), 16'd1);
    check("first_href", 16'(cmos_href), 16'd0);
    vs_len = 0;
    while (cmos_vsync && vs_len < 10) begin
      vs_len++;
      @(negedge clk);
    end
    check("vsync_len", 16'(vs_len), 16'(VS));

    enable = 1'b0;
    repeat (2 * PER) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
